// File: rtl/response_misr.sv
// Response compactor: 24-bit Galois MISR that folds masked core responses into a
// signature and compares it against a golden value captured at session start.
//
// state  | meaning
// IDLE   | no session, waiting for START
// RUN    | compacting responses until N_PATTERNS accepted or ABORT
// DONE   | signature final, PASS valid, held until START or RST
module response_misr #(
    parameter int              WIDTH = 24,
    parameter int              CNT_W = 16,
    parameter logic [WIDTH-1:0] SEED = '0
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [CNT_W-1:0] N_PATTERNS,
    input  logic [WIDTH-1:0] GOLDEN,
    input  logic             RESP_VALID,
    input  logic [WIDTH-1:0] RESP,
    input  logic [WIDTH-1:0] MASK,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [WIDTH-1:0] SIGNATURE,
    output logic [CNT_W-1:0] COUNT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Feedback taps for x^24+x^23+x^22+x^17+1; bit 0 is the feedback itself.
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(24'hC20001);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] npat_q, npat_d;
    logic [WIDTH-1:0] gold_q, gold_d;
    logic             pass_q, pass_d;

    logic [WIDTH-1:0] resp_masked;
    logic [WIDTH-1:0] sig_next;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        resp_masked = RESP & ~MASK;
        sig_next    = {sig_q[WIDTH-2:0], 1'b0} ^ resp_masked
                      ^ (sig_q[WIDTH-1] ? TAPS : '0);
        cnt_inc     = cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        npat_d  = npat_q;
        gold_d  = gold_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    sig_d  = SEED;
                    cnt_d  = '0;
                    npat_d = N_PATTERNS;
                    gold_d = GOLDEN;
                    if (N_PATTERNS == '0) begin
                        state_d = S_DONE;
                        pass_d  = (SEED == GOLDEN);
                    end else begin
                        state_d = S_RUN;
                        pass_d  = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else if (RESP_VALID) begin
                    sig_d = sig_next;
                    cnt_d = cnt_inc;
                    if (cnt_inc == npat_q) begin
                        state_d = S_DONE;
                        pass_d  = (sig_next == gold_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            npat_q  <= '0;
            gold_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            npat_q  <= npat_d;
            gold_q  <= gold_d;
            pass_q  <= pass_d;
        end
    end

    assign BUSY      = (state_q == S_RUN);
    assign DONE      = (state_q == S_DONE);
    assign PASS      = pass_q;
    assign SIGNATURE = sig_q;
    assign COUNT     = cnt_q;

endmodule

// File: tb/tb_response_misr.sv
// Directed bench for response_misr: hand-computed signatures, session control,
// abort, reset and ignored-input cases.
module tb_response_misr;

    logic        CK = 1'b0;
    logic        RST, START, ABORT, RESP_VALID;
    logic [15:0] N_PATTERNS;
    logic [23:0] GOLDEN, RESP, MASK;
    logic        BUSY, DONE, PASS;
    logic [23:0] SIGNATURE;
    logic [15:0] COUNT;

    int n_checks = 0;
    int n_fail   = 0;

    response_misr dut (
        .CK(CK), .RST(RST), .START(START), .ABORT(ABORT),
        .N_PATTERNS(N_PATTERNS), .GOLDEN(GOLDEN), .RESP_VALID(RESP_VALID),
        .RESP(RESP), .MASK(MASK), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
        .SIGNATURE(SIGNATURE), .COUNT(COUNT)
    );

    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic idle_inputs();
        RST = 0; START = 0; ABORT = 0; RESP_VALID = 0;
        RESP = '0; MASK = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        N_PATTERNS = '0; GOLDEN = '0;
        RST = 1;
        tick(); tick();
        RST = 0;
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", BUSY); end
        n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", DONE); end
        n_checks++; if (PASS !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %0b want 0", PASS); end
        n_checks++; if (SIGNATURE !== 24'h000000) begin n_fail++; $display("FAIL reset_sig got %h want 000000", SIGNATURE); end
        n_checks++; if (COUNT !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", COUNT); end
    endtask

    task automatic test_back_to_back(input logic [23:0] gold, input logic exp_pass);
        START = 1; N_PATTERNS = 16'd2; GOLDEN = gold;
        tick();
        START = 0;
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %0b want 1", BUSY); end
        n_checks++; if (SIGNATURE !== 24'h000000 || COUNT !== 16'd0) begin n_fail++; $display("FAIL b2b_seed got %h/%0d want 000000/0", SIGNATURE, COUNT); end
        RESP_VALID = 1; RESP = 24'h800000;
        tick();
        n_checks++; if (SIGNATURE !== 24'h800000 || DONE !== 1'b0) begin n_fail++; $display("FAIL b2b_first got %h done %0b want 800000 done 0", SIGNATURE, DONE); end
        RESP = 24'h000000;
        tick();
        RESP_VALID = 0;
        n_checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_done got done %0b busy %0b want 1 0", DONE, BUSY); end
        n_checks++; if (SIGNATURE !== 24'hC20001) begin n_fail++; $display("FAIL b2b_sig got %h want c20001", SIGNATURE); end
        n_checks++; if (COUNT !== 16'd2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", COUNT); end
        n_checks++; if (PASS !== exp_pass) begin n_fail++; $display("FAIL b2b_pass got %0b want %0b", PASS, exp_pass); end
        // responses and abort while DONE must not disturb anything
        RESP_VALID = 1; RESP = 24'h5A5A5A; ABORT = 1;
        tick(); tick();
        RESP_VALID = 0; ABORT = 0;
        n_checks++; if (DONE !== 1'b1 || SIGNATURE !== 24'hC20001 || COUNT !== 16'd2 || PASS !== exp_pass)
            begin n_fail++; $display("FAIL done_hold got done %0b sig %h cnt %0d pass %0b want 1 c20001 2 %0b", DONE, SIGNATURE, COUNT, PASS, exp_pass); end
    endtask

    task automatic test_gaps();
        START = 1; N_PATTERNS = 16'd2; GOLDEN = 24'h000002;
        tick();
        START = 0; N_PATTERNS = 16'd1; GOLDEN = 24'h000000;
        RESP_VALID = 1; RESP = 24'h000001;
        tick();
        RESP_VALID = 0; RESP = 24'hFFFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (BUSY !== 1'b1 || SIGNATURE !== 24'h000001 || COUNT !== 16'd1)
                begin n_fail++; $display("FAIL gap_hold[%0d] got busy %0b sig %h cnt %0d want 1 000001 1", i, BUSY, SIGNATURE, COUNT); end
        end
        RESP_VALID = 1; RESP = 24'h000000;
        tick();
        RESP_VALID = 0;
        n_checks++; if (SIGNATURE !== 24'h000002 || COUNT !== 16'd2) begin n_fail++; $display("FAIL gap_final got %h/%0d want 000002/2", SIGNATURE, COUNT); end
        n_checks++; if (DONE !== 1'b1 || PASS !== 1'b1) begin n_fail++; $display("FAIL gap_pass got done %0b pass %0b want 1 1", DONE, PASS); end
    endtask

    task automatic test_mask();
        START = 1; N_PATTERNS = 16'd1; GOLDEN = 24'h000000;
        tick();
        START = 0;
        RESP_VALID = 1; RESP = 24'hFFFFFF; MASK = 24'hFFFFFF;
        tick();
        RESP_VALID = 0; MASK = '0;
        n_checks++; if (SIGNATURE !== 24'h000000 || DONE !== 1'b1 || PASS !== 1'b1 || COUNT !== 16'd1)
            begin n_fail++; $display("FAIL mask got sig %h done %0b pass %0b cnt %0d want 000000 1 1 1", SIGNATURE, DONE, PASS, COUNT); end
    endtask

    task automatic test_zero_patterns();
        START = 1; N_PATTERNS = 16'd0; GOLDEN = 24'h000000;
        @(posedge CK);
        #1;
        START = 0;
        n_checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin n_fail++; $display("FAIL zero_state got done %0b busy %0b want 1 0", DONE, BUSY); end
        n_checks++; if (PASS !== 1'b1 || COUNT !== 16'd0 || SIGNATURE !== 24'h000000)
            begin n_fail++; $display("FAIL zero_result got pass %0b cnt %0d sig %h want 1 0 000000", PASS, COUNT, SIGNATURE); end
        START = 1; GOLDEN = 24'h000001;
        tick();
        START = 0;
        n_checks++; if (DONE !== 1'b1 || PASS !== 1'b0) begin n_fail++; $display("FAIL zero_badgold got done %0b pass %0b want 1 0", DONE, PASS); end
    endtask

    task automatic test_abort();
        START = 1; N_PATTERNS = 16'd4; GOLDEN = 24'h000000;
        tick();
        START = 0;
        RESP_VALID = 1; RESP = 24'h000001;
        tick(); tick();
        ABORT = 1; RESP = 24'hFFFFFF;
        tick();
        ABORT = 0; RESP_VALID = 0;
        n_checks++; if (BUSY !== 1'b0 || DONE !== 1'b0 || PASS !== 1'b0)
            begin n_fail++; $display("FAIL abort_state got busy %0b done %0b pass %0b want 0 0 0", BUSY, DONE, PASS); end
        n_checks++; if (COUNT !== 16'd2 || SIGNATURE !== 24'h000003)
            begin n_fail++; $display("FAIL abort_hold got cnt %0d sig %h want 2 000003", COUNT, SIGNATURE); end
        ABORT = 1; RESP_VALID = 1; RESP = 24'h123456;
        tick(); tick();
        ABORT = 0; RESP_VALID = 0;
        n_checks++; if (BUSY !== 1'b0 || DONE !== 1'b0 || COUNT !== 16'd2 || SIGNATURE !== 24'h000003)
            begin n_fail++; $display("FAIL idle_ignore got busy %0b done %0b cnt %0d sig %h want 0 0 2 000003", BUSY, DONE, COUNT, SIGNATURE); end
    endtask

    task automatic test_start_in_run();
        START = 1; N_PATTERNS = 16'd3; GOLDEN = 24'h000004;
        tick();
        START = 0;
        RESP_VALID = 1; RESP = 24'h000001;
        tick();
        START = 1; N_PATTERNS = 16'd9; RESP = 24'h000000;
        tick();
        START = 0;
        n_checks++; if (BUSY !== 1'b1 || COUNT !== 16'd2 || SIGNATURE !== 24'h000002)
            begin n_fail++; $display("FAIL start_in_run got busy %0b cnt %0d sig %h want 1 2 000002", BUSY, COUNT, SIGNATURE); end
        tick();
        RESP_VALID = 0;
        n_checks++; if (DONE !== 1'b1 || COUNT !== 16'd3 || SIGNATURE !== 24'h000004 || PASS !== 1'b1)
            begin n_fail++; $display("FAIL start_in_run_end got done %0b cnt %0d sig %h pass %0b want 1 3 000004 1", DONE, COUNT, SIGNATURE, PASS); end
    endtask

    task automatic test_rst_mid_run();
        START = 1; N_PATTERNS = 16'd4; GOLDEN = 24'h000000;
        tick();
        START = 0;
        RESP_VALID = 1; RESP = 24'h00F00F;
        tick();
        n_checks++; if (BUSY !== 1'b1 || SIGNATURE !== 24'h00F00F) begin n_fail++; $display("FAIL rst_pre got busy %0b sig %h want 1 00f00f", BUSY, SIGNATURE); end
        RST = 1; START = 1; ABORT = 1;
        tick();
        idle_inputs();
        n_checks++; if (BUSY !== 1'b0 || DONE !== 1'b0 || PASS !== 1'b0 || SIGNATURE !== 24'h000000 || COUNT !== 16'd0)
            begin n_fail++; $display("FAIL rst_mid got busy %0b done %0b pass %0b sig %h cnt %0d want 0 0 0 000000 0", BUSY, DONE, PASS, SIGNATURE, COUNT); end
        tick();
        n_checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_fail++; $display("FAIL rst_after got busy %0b done %0b want 0 0", BUSY, DONE); end
    endtask

    initial begin
        test_reset();
        test_back_to_back(24'hC20001, 1'b1);
        test_back_to_back(24'hC20000, 1'b0);
        test_gaps();
        test_mask();
        test_zero_patterns();
        test_abort();
        test_start_in_run();
        test_rst_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/response_misr.md
RESPONSE_MISR -- requirements
Module: response_misr

Interface
REQ-001 Parameter: WIDTH, 24, response/signature width; matches the 24 primary outputs of the upstream benchmark core.
REQ-002 Parameter: CNT_W, 16, pattern-counter width.
REQ-003 Parameter: SEED, 24'h000000, signature value loaded at START.
REQ-004 Port: CK  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: RST  input  1  reset, synchronous, active-high.
REQ-006 Port: START  input  1  begins a compaction session; ignored unless state is IDLE or DONE.
REQ-007 Port: ABORT  input  1  cancels a session in RUN.
REQ-008 Port: N_PATTERNS  input  CNT_W  number of responses to compact; sampled on the accepted START cycle.
REQ-009 Port: GOLDEN  input  WIDTH  expected signature; sampled on the accepted START cycle.
REQ-010 Port: RESP_VALID  input  1  RESP carries one core response this cycle.
REQ-011 Port: RESP  input  WIDTH  captured core outputs, bit i = output i.
REQ-012 Port: MASK  input  WIDTH  per-bit X-mask; 1 forces that RESP bit to 0 before compaction.
REQ-013 Port: BUSY  output  1  high in RUN.
REQ-014 Port: DONE  output  1  high in DONE.
REQ-015 Port: PASS  output  1  final signature equals captured GOLDEN; meaningful only when DONE=1.
REQ-016 Port: SIGNATURE  output  WIDTH  current MISR state.
REQ-017 Port: COUNT  output  CNT_W  responses accepted in current/last session.

Function
REQ-018 FSM states: IDLE, RUN, DONE; all outputs registered.
REQ-019 IDLE/DONE + START=1 -> RUN next cycle; same edge: SIGNATURE<=SEED, COUNT<=0, PASS<=0, N_PATTERNS and GOLDEN captured.
REQ-020 Exception: START with N_PATTERNS=0 -> DONE directly; SIGNATURE<=SEED, COUNT<=0, PASS<=(SEED==GOLDEN).
REQ-021 RESP is accepted only when state=RUN and RESP_VALID=1; RESP_VALID in IDLE/DONE ignored, no state change.
REQ-022 Per accepted cycle, with d = RESP & ~MASK and fb = SIGNATURE[WIDTH-1]: next[0] = fb ^ d[0]; next[i] = SIGNATURE[i-1] ^ d[i] for i>=1, additionally ^ fb for i in {17,22,23} (polynomial x^24+x^23+x^22+x^17+1, Galois form).
REQ-023 Per accepted cycle COUNT increments by 1; no wrap possible since session ends at N_PATTERNS.
REQ-024 Accepted cycle where COUNT+1 == captured N_PATTERNS -> DONE next cycle; PASS<=(next signature == captured GOLDEN), i.e. one-cycle latency from last response to DONE/PASS.
REQ-025 RUN with RESP_VALID=0: signature and COUNT hold; no timeout.
REQ-026 ABORT=1 in RUN -> IDLE next cycle; RESP on that cycle not compacted; DONE/PASS stay 0; SIGNATURE and COUNT hold.
REQ-027 ABORT outside RUN ignored; ABORT has priority over RESP_VALID; START in RUN ignored.
REQ-028 DONE is held, SIGNATURE/COUNT/PASS stable, until START or RST.
REQ-029 GOLDEN/N_PATTERNS changes after START do not affect the session.

Reset
REQ-030 RST=1 at a rising edge -> IDLE; BUSY=0, DONE=0, PASS=0, SIGNATURE=SEED, COUNT=0; overrides START, ABORT, RESP_VALID, including mid-RUN.

Verification
REQ-031 START, N=2, MASK=0, RESP 24'h800000 then 24'h000000 (valid back-to-back) -> SIGNATURE=24'hC20001, COUNT=2, DONE one cycle after 2nd response; GOLDEN=24'hC20001 -> PASS=1, GOLDEN=24'hC20000 -> PASS=0.
REQ-032 N=2, RESP 24'h000001 then 24'h000000 with RESP_VALID gaps of 3 idle cycles -> SIGNATURE=24'h000002, COUNT=2, BUSY held through gaps.
REQ-033 N=1, RESP=24'hFFFFFF, MASK=24'hFFFFFF, GOLDEN=0 -> SIGNATURE=0, PASS=1.
REQ-034 N=0, GOLDEN=0 -> DONE=1 cycle after START, BUSY never 1, PASS=1, COUNT=0.
REQ-035 N=4, ABORT after 2 responses -> IDLE, COUNT=2, DONE=0; RST asserted mid-RUN in a second session -> all outputs at reset values next cycle.
REQ-036 START during RUN and RESP_VALID in IDLE/DONE -> no effect on SIGNATURE, COUNT, or state.
